// File: rtl/lcd_nibble_sequencer_if.sv
// CPU-side byte handshake and LCD pin bundle for the nibble sequencer.
// The master drives byte requests; the slave (sequencer) drives the LCD pins.
interface lcd_nibble_sequencer_if;
    logic       iValid;
    logic       iRS;
    logic [7:0] iData;
    logic       oReady;
    logic       oInitDone;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    modport master (
        output iValid, iRS, iData,
        input  oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );

    modport slave (
        input  iValid, iRS, iData,
        output oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );
endinterface

// File: rtl/lcd_nibble_sequencer.sv
// HD44780 4-bit write-only sequencer: power-on init, then one byte per request split into
// two timed nibble strobes followed by the command execution wait.
module lcd_nibble_sequencer #(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EHIGH = 12,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_GAP   = 50,
    parameter int unsigned T_CLEAR = 82000,
    parameter int unsigned CW      = 20
) (
    input logic                   Clock,
    input logic                   Reset,
    lcd_nibble_sequencer_if.slave bus
);

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TStrobe  = T_SETUP + T_EHIGH + T_HOLD;
    localparam int unsigned MaxDelay = max2(max2(max2(T_PWR, T_INIT1), max2(T_INIT2, T_CMD)),
                                            max2(max2(TStrobe, T_GAP), T_CLEAR));

    localparam logic [CW-1:0] LastPwr    = CW'(T_PWR - 1);
    localparam logic [CW-1:0] LastInit1  = CW'(T_INIT1 - 1);
    localparam logic [CW-1:0] LastInit2  = CW'(T_INIT2 - 1);
    localparam logic [CW-1:0] LastCmd    = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LastClear  = CW'(T_CLEAR - 1);
    localparam logic [CW-1:0] LastStrobe = CW'(TStrobe - 1);
    localparam logic [CW-1:0] LastSetup  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LastEhigh  = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] LastHold   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LastGap    = CW'(T_GAP - 1);
    localparam logic [CW-1:0] EStart     = CW'(T_SETUP);
    localparam logic [CW-1:0] EStop      = CW'(T_SETUP + T_EHIGH);

    typedef enum logic [3:0] {
        StPwrWait, StInitStrobe, StInitWait, StIdle,
        StHiSetup, StHiE, StHiHold, StGap,
        StLoSetup, StLoE, StLoHold, StExecWait
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    step_q, step_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          e_q, e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [3:0]    lcd_d_q, lcd_d_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [CW-1:0] init_last;
    logic [CW-1:0] exec_last;
    logic          is_clear;

    always_comb begin
        init_last = LastCmd;
        if (step_q == 2'd0) begin
            init_last = LastInit1;
        end else if (step_q == 2'd1) begin
            init_last = LastInit2;
        end
    end

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_clear  = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign exec_last = is_clear ? LastClear : LastCmd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        step_d  = step_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            StPwrWait:    if (cnt_q == LastPwr)    state_d = StInitStrobe;
            StInitStrobe: if (cnt_q == LastStrobe) state_d = StInitWait;
            StInitWait: begin
                if (cnt_q == init_last) begin
                    state_d = (step_q == 2'd3) ? StIdle : StInitStrobe;
                    step_d  = step_q + 2'd1;
                end
            end
            StIdle: begin
                if (bus.iValid && ready_q) begin
                    state_d = StHiSetup;
                    rs_d    = bus.iRS;
                    data_d  = bus.iData;
                end
            end
            StHiSetup:  if (cnt_q == LastSetup) state_d = StHiE;
            StHiE:      if (cnt_q == LastEhigh) state_d = StHiHold;
            StHiHold:   if (cnt_q == LastHold)  state_d = StGap;
            StGap:      if (cnt_q == LastGap)   state_d = StLoSetup;
            StLoSetup:  if (cnt_q == LastSetup) state_d = StLoE;
            StLoE:      if (cnt_q == LastEhigh) state_d = StLoHold;
            StLoHold:   if (cnt_q == LastHold)  state_d = StExecWait;
            StExecWait: if (cnt_q == exec_last) state_d = StIdle;
            default:    state_d = StPwrWait;
        endcase
        // Counter restarts on every state entry and sits at zero while idle.
        if ((state_d != state_q) || (state_q == StIdle)) begin
            cnt_d = '0;
        end
    end

    // Pin values are decoded from the next state so the registered outputs line up with it.
    always_comb begin
        e_d      = 1'b0;
        lcd_rs_d = 1'b0;
        lcd_d_d  = 4'h0;
        case (state_d)
            StInitStrobe: begin
                lcd_d_d = (step_d == 2'd3) ? 4'h2 : 4'h3;
                e_d     = (cnt_d >= EStart) && (cnt_d < EStop);
            end
            StHiSetup, StHiHold: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[7:4];
            end
            StHiE: begin
                e_d      = 1'b1;
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[7:4];
            end
            StLoSetup, StLoHold: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[3:0];
            end
            StLoE: begin
                e_d      = 1'b1;
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[3:0];
            end
            default: ;
        endcase
    end

    assign ready_d = (state_d == StIdle);
    assign done_d  = done_q | ready_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StPwrWait;
            cnt_q    <= '0;
            step_q   <= 2'd0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            e_q      <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_d_q  <= 4'h0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            e_q      <= e_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_d_q  <= lcd_d_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.oReady    = ready_q;
    assign bus.oInitDone = done_q;
    assign bus.oLCD_E    = e_q;
    assign bus.oLCD_RS   = lcd_rs_q;
    assign bus.oLCD_RW   = 1'b0;
    assign bus.oLCD_D    = lcd_d_q;

    param_check_a: assert property (@(posedge Clock)
        (T_PWR != 0) && (T_INIT1 != 0) && (T_INIT2 != 0) && (T_CMD != 0) &&
        (T_SETUP != 0) && (T_EHIGH != 0) && (T_HOLD != 0) && (T_GAP != 0) &&
        (T_CLEAR != 0) && (CW >= $clog2(MaxDelay + 1)));

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Scoreboard bench: stimulus pushes expected E pulses and busy lengths, a negedge monitor
// measures the pins and pops/compares.
module tb_lcd_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_nibble_sequencer_if bus ();

    lcd_nibble_sequencer #(
        .T_PWR   (20),
        .T_INIT1 (10),
        .T_INIT2 (6),
        .T_CMD   (4),
        .T_SETUP (2),
        .T_EHIGH (3),
        .T_HOLD  (1),
        .T_GAP   (3),
        .T_CLEAR (9),
        .CW      (20)
    ) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int d;
        int rs;
        int w;
        int gap;  // 0 = spacing from previous rise not checked
    } pulse_t;

    pulse_t pq[$];
    int     rq[$];
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor state
    bit in_pulse = 0;
    int width = 0;
    int cur_d = 0;
    int cur_rs = 0;
    int cur_gap = -1;
    int rise_cnt = -1;
    bit in_low = 0;
    int low_len = 0;
    bit ready_prev = 0;

    task automatic finish_pulse();
        pulse_t p;
        if (pq.size() == 0) begin
            check("extra_pulse_width", width, 0);
        end else begin
            p = pq.pop_front();
            check("pulse_d", cur_d, p.d);
            check("pulse_rs", cur_rs, p.rs);
            check("pulse_width", width, p.w);
            if (p.gap != 0) check("rise_spacing", cur_gap, p.gap);
        end
        in_pulse = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_pulse) finish_pulse();
            in_low = 0;
            ready_prev = 0;
            rise_cnt = -1;
        end else begin
            check("rw_zero", bus.oLCD_RW, 0);
            if (bus.oLCD_E) begin
                if (!in_pulse) begin
                    in_pulse = 1;
                    width = 0;
                    cur_d = bus.oLCD_D;
                    cur_rs = bus.oLCD_RS;
                    cur_gap = rise_cnt;
                    rise_cnt = 0;
                end else begin
                    check("d_stable_e", bus.oLCD_D, cur_d);
                    check("rs_stable_e", bus.oLCD_RS, cur_rs);
                end
                width++;
            end else if (in_pulse) begin
                check("d_stable_hold", bus.oLCD_D, cur_d);
                check("rs_stable_hold", bus.oLCD_RS, cur_rs);
                finish_pulse();
            end
            if (rise_cnt >= 0) rise_cnt++;

            if (ready_prev && !bus.oReady) begin
                in_low = 1;
                low_len = 0;
            end
            if (in_low) begin
                if (bus.oReady) begin
                    if (rq.size() == 0) check("extra_busy_len", low_len, 0);
                    else check("busy_len", low_len, rq.pop_front());
                    in_low = 0;
                end else begin
                    low_len++;
                end
            end
            ready_prev = bus.oReady;
        end
    end

    task automatic push_pulse(int d, int rs, int w, int gap);
        pulse_t p;
        p.d = d;
        p.rs = rs;
        p.w = w;
        p.gap = gap;
        pq.push_back(p);
    endtask

    // Release reset and time the init sequence: 20 + 4*6 + 10 + 6 + 4 + 4 = 68 cycles.
    task automatic do_init();
        int n = 0;
        push_pulse(3, 0, 3, 0);
        push_pulse(3, 0, 3, 16);
        push_pulse(3, 0, 3, 12);
        push_pulse(2, 0, 3, 10);
        @(negedge clk);
        #2 rst_n = 1'b1;
        while (!bus.oInitDone && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("init_cycles", n, 68);
        check("init_ready", bus.oReady, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.oReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.oReady) check("wait_ready", bus.oReady, 1);
    endtask

    // lo_w < 3 marks a low-nibble pulse cut short by reset; busy = 0 pushes no busy length.
    task automatic issue(bit rs, logic [7:0] data, int busy, int lo_w);
        wait_ready();
        push_pulse(int'(data[7:4]), int'(rs), 3, 0);
        push_pulse(int'(data[3:0]), int'(rs), lo_w, 9);
        if (busy != 0) rq.push_back(busy);
        bus.iValid = 1'b1;
        bus.iRS = rs;
        bus.iData = data;
        @(negedge clk);
        bus.iValid = 1'b0;
    endtask

    typedef struct {
        bit         rs;
        logic [7:0] data;
        int         busy;
    } vec_t;

    vec_t vecs[7] = '{
        '{1'b1, 8'h48, 19},   // 'H'
        '{1'b0, 8'h01, 24},   // clear
        '{1'b0, 8'h02, 24},   // home
        '{1'b0, 8'h03, 24},   // home
        '{1'b0, 8'h04, 19},   // just above the clear/home range
        '{1'b1, 8'h01, 19},   // data 0x01 is not a clear
        '{1'b0, 8'h00, 19}
    };

    initial begin
        int n;
        bus.iValid = 1'b0;
        bus.iRS = 1'b0;
        bus.iData = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.oReady, 0);
        check("rst_done", bus.oInitDone, 0);
        check("rst_e", bus.oLCD_E, 0);
        check("rst_d", bus.oLCD_D, 0);
        check("rst_rs", bus.oLCD_RS, 0);
        do_init();

        foreach (vecs[i]) issue(vecs[i].rs, vecs[i].data, vecs[i].busy, 3);

        // Request while busy is dropped; a held request is taken on the first idle cycle.
        issue(1'b0, 8'h28, 19, 3);
        repeat (4) @(negedge clk);
        bus.iValid = 1'b1;
        bus.iRS = 1'b1;
        bus.iData = 8'h55;
        @(negedge clk);
        bus.iValid = 1'b0;
        push_pulse(0, 0, 3, 0);
        push_pulse(12, 0, 3, 9);
        rq.push_back(19);
        bus.iRS = 1'b0;
        bus.iData = 8'h0C;
        bus.iValid = 1'b1;
        n = 0;
        while (!bus.oReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("zero_idle_gap", bus.oReady, 0);
        bus.iValid = 1'b0;

        // Reset in the 2nd cycle of the low-nibble E pulse.
        issue(1'b1, 8'h48, 0, 2);
        n = 0;
        while (!(bus.oLCD_E && bus.oLCD_D == 4'h8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lo_e_seen", bus.oLCD_E, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_e", bus.oLCD_E, 0);
        check("async_d", bus.oLCD_D, 0);
        check("async_rs", bus.oLCD_RS, 0);
        check("async_ready", bus.oReady, 0);
        check("async_done", bus.oInitDone, 0);
        repeat (3) @(negedge clk);
        do_init();
        issue(1'b1, 8'h41, 19, 3);

        wait_ready();
        repeat (3) @(negedge clk);
        check("pulse_q_drained", pq.size(), 0);
        check("busy_q_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
